// File: rtl/pkt_receiver.sv
// pkt_receiver: RX-side packet receiver for the top-k kernel.
// Accepts TCP RX notifications, issues one read request at a time, checks
// the returned metadata session, and forwards payload beats downstream as
// {length, sessionID, tlast, tdata} through a single-entry output register.
`timescale 1ns/1ps

module pkt_receiver #(
  parameter int NOTIF_W = 88,
  parameter int DATA_W  = 512,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // RX notifications from the TCP/IP stack
  input  logic [NOTIF_W-1:0]    s_axis_notifications_TDATA,
  input  logic                  s_axis_notifications_TVALID,
  output logic                  s_axis_notifications_TREADY,
  // Read requests {length, sessionID}
  output logic [31:0]           m_axis_read_package_TDATA,
  output logic                  m_axis_read_package_TVALID,
  input  logic                  m_axis_read_package_TREADY,
  // RX metadata (sessionID of returned data)
  input  logic [15:0]           s_axis_rx_metadata_TDATA,
  input  logic                  s_axis_rx_metadata_TVALID,
  output logic                  s_axis_rx_metadata_TREADY,
  // RX payload
  input  logic [DATA_W-1:0]     s_axis_rx_data_TDATA,
  input  logic [DATA_W/8-1:0]   s_axis_rx_data_TKEEP,
  input  logic                  s_axis_rx_data_TLAST,
  input  logic                  s_axis_rx_data_TVALID,
  output logic                  s_axis_rx_data_TREADY,
  // Packet stream to the kernel
  output logic [DATA_W+32:0]    pkt_tx_TDATA,
  output logic                  pkt_tx_TVALID,
  input  logic                  pkt_tx_TREADY,
  // Statistics and error
  output logic [CNT_W-1:0]      stat_pkts,
  output logic [CNT_W-1:0]      stat_bytes,
  output logic [CNT_W-1:0]      stat_dropped,
  output logic                  err_session_mismatch
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int POP_W  = $clog2(KEEP_W + 1);
  localparam int PKT_W  = DATA_W + 33;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_META,
    S_DATA
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [15:0]         r_session;
  logic [15:0]         r_length;

  logic [PKT_W-1:0]    r_out_data;
  logic                r_out_valid;

  logic [CNT_W-1:0]    r_stat_pkts;
  logic [CNT_W-1:0]    r_stat_bytes;
  logic [CNT_W-1:0]    r_stat_dropped;
  logic                r_err_mismatch;

  logic                w_notif_ready;
  logic                w_req_valid;
  logic                w_meta_ready;
  logic                w_data_ready;
  logic                w_notif_fire;
  logic                w_req_fire;
  logic                w_meta_fire;
  logic                w_data_fire;
  logic                w_out_fire;
  logic                w_last_fire;

  logic [15:0]         w_notif_session;
  logic [15:0]         w_notif_length;
  logic                w_notif_closed;
  logic                w_notif_drop;
  logic [POP_W-1:0]    w_keep_cnt;
  logic                w_unused_notif;

  // Notification field decode; IP and dstPort are not needed on the RX path.
  assign w_notif_session = s_axis_notifications_TDATA[15:0];
  assign w_notif_length  = s_axis_notifications_TDATA[31:16];
  assign w_notif_closed  = s_axis_notifications_TDATA[80];
  assign w_notif_drop    = w_notif_closed || (w_notif_length == 16'd0);
  assign w_unused_notif  = ^{s_axis_notifications_TDATA[NOTIF_W-1:81],
                             s_axis_notifications_TDATA[79:32]};

  // Handshake signals are forced low while reset is held.
  assign w_notif_ready = !rst && (r_state == S_IDLE);
  assign w_req_valid   = !rst && (r_state == S_REQ);
  assign w_meta_ready  = !rst && (r_state == S_META);
  assign w_data_ready  = !rst && (r_state == S_DATA) && (!r_out_valid || pkt_tx_TREADY);

  assign w_notif_fire = s_axis_notifications_TVALID && w_notif_ready;
  assign w_req_fire   = w_req_valid && m_axis_read_package_TREADY;
  assign w_meta_fire  = s_axis_rx_metadata_TVALID && w_meta_ready;
  assign w_data_fire  = s_axis_rx_data_TVALID && w_data_ready;
  assign w_out_fire   = r_out_valid && pkt_tx_TREADY;
  assign w_last_fire  = w_data_fire && s_axis_rx_data_TLAST;

  // Count enabled bytes of the incoming beat.
  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_keep_cnt = w_keep_cnt + POP_W'(s_axis_rx_data_TKEEP[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: one read transaction in flight at a time.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_notif_fire && !w_notif_drop) w_next_state = S_REQ;
      S_REQ:  if (w_req_fire)                    w_next_state = S_META;
      S_META: if (w_meta_fire)                   w_next_state = S_DATA;
      S_DATA: if (w_last_fire)                   w_next_state = S_IDLE;
      default:                                   w_next_state = S_IDLE;
    endcase
  end

  // Latch session and length of an accepted, non-dropped notification.
  always_ff @(posedge clk) begin
    if (w_notif_fire && !w_notif_drop) begin
      r_session <= w_notif_session;
      r_length  <= w_notif_length;
    end
  end

  // Output register occupancy: load wins over unload so back-to-back beats flow.
  always_ff @(posedge clk) begin
    if (rst)              r_out_valid <= 1'b0;
    else if (w_data_fire) r_out_valid <= 1'b1;
    else if (w_out_fire)  r_out_valid <= 1'b0;
  end

  // Output register payload, tagged with the latched session and length.
  always_ff @(posedge clk) begin
    // NOTE: the payload is left out of reset; r_out_valid alone marks it meaningful.
    if (w_data_fire) begin
      r_out_data <= {r_length, r_session, s_axis_rx_data_TLAST, s_axis_rx_data_TDATA};
    end
  end

  // Statistics counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_pkts    <= '0;
      r_stat_bytes   <= '0;
      r_stat_dropped <= '0;
    end else begin
      if (w_last_fire)                  r_stat_pkts    <= r_stat_pkts + 1'b1;
      if (w_data_fire)                  r_stat_bytes   <= r_stat_bytes + CNT_W'(w_keep_cnt);
      if (w_notif_fire && w_notif_drop) r_stat_dropped <= r_stat_dropped + 1'b1;
    end
  end

  // Sticky flag: returned metadata named a different session than requested.
  always_ff @(posedge clk) begin
    if (rst)                                                       r_err_mismatch <= 1'b0;
    else if (w_meta_fire && (s_axis_rx_metadata_TDATA != r_session)) r_err_mismatch <= 1'b1;
  end

  assign s_axis_notifications_TREADY = w_notif_ready;
  assign m_axis_read_package_TDATA   = {r_length, r_session};
  assign m_axis_read_package_TVALID  = w_req_valid;
  assign s_axis_rx_metadata_TREADY   = w_meta_ready;
  assign s_axis_rx_data_TREADY       = w_data_ready;
  assign pkt_tx_TDATA                = r_out_data;
  assign pkt_tx_TVALID               = r_out_valid;
  assign stat_pkts                   = r_stat_pkts;
  assign stat_bytes                  = r_stat_bytes;
  assign stat_dropped                = r_stat_dropped;
  assign err_session_mismatch        = r_err_mismatch;

endmodule

// File: tb/tb_pkt_receiver.sv
// Testbench for pkt_receiver: directed scenarios followed by randomized
// packets, with a queue-based model of the forwarded stream and statistics.
`timescale 1ns/1ps

module tb_pkt_receiver;

  localparam int NOTIF_W = 88;
  localparam int DATA_W  = 512;
  localparam int CNT_W   = 32;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int PKT_W   = DATA_W + 33;

  logic                 clk;
  logic                 rst;
  logic [NOTIF_W-1:0]   notif_tdata;
  logic                 notif_tvalid;
  logic                 notif_tready;
  logic [31:0]          req_tdata;
  logic                 req_tvalid;
  logic                 req_tready;
  logic [15:0]          meta_tdata;
  logic                 meta_tvalid;
  logic                 meta_tready;
  logic [DATA_W-1:0]    data_tdata;
  logic [KEEP_W-1:0]    data_tkeep;
  logic                 data_tlast;
  logic                 data_tvalid;
  logic                 data_tready;
  logic [PKT_W-1:0]     pkt_tdata;
  logic                 pkt_tvalid;
  logic                 pkt_tready;
  logic [CNT_W-1:0]     stat_pkts;
  logic [CNT_W-1:0]     stat_bytes;
  logic [CNT_W-1:0]     stat_dropped;
  logic                 err_mismatch;

  pkt_receiver #(.NOTIF_W(NOTIF_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .s_axis_notifications_TDATA  (notif_tdata),
    .s_axis_notifications_TVALID (notif_tvalid),
    .s_axis_notifications_TREADY (notif_tready),
    .m_axis_read_package_TDATA   (req_tdata),
    .m_axis_read_package_TVALID  (req_tvalid),
    .m_axis_read_package_TREADY  (req_tready),
    .s_axis_rx_metadata_TDATA    (meta_tdata),
    .s_axis_rx_metadata_TVALID   (meta_tvalid),
    .s_axis_rx_metadata_TREADY   (meta_tready),
    .s_axis_rx_data_TDATA        (data_tdata),
    .s_axis_rx_data_TKEEP        (data_tkeep),
    .s_axis_rx_data_TLAST        (data_tlast),
    .s_axis_rx_data_TVALID       (data_tvalid),
    .s_axis_rx_data_TREADY       (data_tready),
    .pkt_tx_TDATA                (pkt_tdata),
    .pkt_tx_TVALID               (pkt_tvalid),
    .pkt_tx_TREADY               (pkt_tready),
    .stat_pkts                   (stat_pkts),
    .stat_bytes                  (stat_bytes),
    .stat_dropped                (stat_dropped),
    .err_session_mismatch        (err_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard counts.
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [PKT_W-1:0]  exp_q[$];
  logic [CNT_W-1:0]  exp_pkts;
  logic [CNT_W-1:0]  exp_bytes;
  logic [CNT_W-1:0]  exp_dropped;
  logic              exp_err;
  logic [31:0]       exp_req;
  logic              req_pending;
  logic [15:0]       cur_sid;
  logic [15:0]       cur_len;

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random, 3 stalled.
  int                tx_mode;

  // Handshakes observed in the most recent cycle.
  logic f_notif, f_read, f_meta, f_data;

  localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KEEP_W-1:0] rand_keep();
    logic [KEEP_W-1:0] k;
    k = {$urandom, $urandom};
    return k;
  endfunction

  // One clock: drive downstream ready, observe at the falling edge, return #1 after the rising edge.
  task automatic clk_step();
    case (tx_mode)
      0:       pkt_tready = 1'b1;
      1:       pkt_tready = ~pkt_tready;
      2:       pkt_tready = 1'($urandom_range(0, 1));
      default: pkt_tready = 1'b0;
    endcase
    @(negedge clk);
    f_notif = notif_tvalid && notif_tready;
    f_read  = req_tvalid && req_tready;
    f_meta  = meta_tvalid && meta_tready;
    f_data  = data_tvalid && data_tready;
    if (req_tvalid) begin
      check("req_expected", 1'b1, req_pending);
      check("req_data", req_tdata, exp_req);
      if (f_read) req_pending = 1'b0;
    end
    if (pkt_tvalid && !pkt_tready) check("no_accept_full", data_tready, 1'b0);
    if (pkt_tvalid && pkt_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 1'b1, 1'b0);
      else                   check("beat", pkt_tdata, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (f_data) check("lat1_valid", pkt_tvalid, 1'b1);
  endtask

  task automatic send_notif(input logic [15:0] sid, input logic [15:0] len, input logic closed);
    notif_tdata  = {7'd0, closed, 16'($urandom), 32'($urandom), len, sid};
    notif_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      clk_step();
      if (f_notif) break;
    end
    check("notif_accept", f_notif, 1'b1);
    notif_tvalid = 1'b0;
    if (closed || len == 16'd0) begin
      exp_dropped = exp_dropped + 1'b1;
    end else begin
      cur_sid     = sid;
      cur_len     = len;
      exp_req     = {len, sid};
      req_pending = 1'b1;
    end
  endtask

  task automatic serve_req();
    for (int k = 0; k < 200; k++) begin
      req_tready = 1'($urandom_range(0, 1));
      clk_step();
      if (f_read) break;
    end
    check("req_accept", f_read, 1'b1);
    req_tready = 1'b0;
  endtask

  task automatic send_meta(input logic [15:0] sid);
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) clk_step();
    meta_tdata  = sid;
    meta_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      clk_step();
      if (f_meta) break;
    end
    check("meta_accept", f_meta, 1'b1);
    meta_tvalid = 1'b0;
    if (sid != cur_sid) exp_err = 1'b1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] keep,
                           input logic last, input int gap);
    if (gap > 0) begin
      data_tvalid = 1'b0;
      for (int g = 0; g < gap; g++) clk_step();
    end
    data_tdata  = d;
    data_tkeep  = keep;
    data_tlast  = last;
    data_tvalid = 1'b1;
    exp_q.push_back({cur_len, cur_sid, last, d});
    exp_bytes = exp_bytes + CNT_W'($countones(keep));
    if (last) exp_pkts = exp_pkts + 1'b1;
    for (int k = 0; k < 200; k++) begin
      clk_step();
      if (f_data) break;
    end
    check("data_accept", f_data, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) clk_step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_stats();
    check("stat_pkts", stat_pkts, exp_pkts);
    check("stat_bytes", stat_bytes, exp_bytes);
    check("stat_dropped", stat_dropped, exp_dropped);
    check("err_mismatch", err_mismatch, exp_err);
  endtask

  task automatic do_packet(input logic [15:0] sid, input logic [15:0] len, input logic [15:0] meta_sid,
                           input int nbeats, input logic [KEEP_W-1:0] last_keep, input int gap_max);
    send_notif(sid, len, 1'b0);
    serve_req();
    send_meta(meta_sid);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(rand_data(), (i == nbeats - 1) ? last_keep : KEEP_ALL, i == nbeats - 1,
                int'($urandom_range(0, gap_max)));
    end
    data_tvalid = 1'b0;
    drain();
    check_stats();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pkts    = '0;
    exp_bytes   = '0;
    exp_dropped = '0;
    exp_err     = 1'b0;
    req_pending = 1'b0;
    exp_req     = '0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    notif_tdata  = '0;
    notif_tvalid = 1'b0;
    req_tready   = 1'b0;
    meta_tdata   = '0;
    meta_tvalid  = 1'b0;
    data_tdata   = '0;
    data_tkeep   = '0;
    data_tlast   = 1'b0;
    data_tvalid  = 1'b0;
    pkt_tready   = 1'b0;
    tx_mode      = 0;
    cur_sid      = '0;
    cur_len      = '0;
    model_reset();

    // Reset state.
    repeat (3) clk_step();
    check("rst_notif_ready", notif_tready, 1'b0);
    check("rst_req_valid", req_tvalid, 1'b0);
    check("rst_meta_ready", meta_tready, 1'b0);
    check("rst_data_ready", data_tready, 1'b0);
    check("rst_pkt_valid", pkt_tvalid, 1'b0);
    check_stats();
    rst = 1'b0;
    clk_step();
    check("idle_notif_ready", notif_tready, 1'b1);

    // Basic 2-beat packet for session 5, length 128.
    do_packet(16'h0005, 16'd128, 16'h0005, 2, KEEP_ALL, 0);

    // Closed and zero-length notifications are dropped without a read request.
    send_notif(16'h0007, 16'd64, 1'b1);
    send_notif(16'h0008, 16'd0, 1'b0);
    repeat (3) clk_step();
    check("drop_idle_ready", notif_tready, 1'b1);
    check_stats();

    // Downstream ready toggling during an 8-beat packet.
    tx_mode = 1;
    do_packet(16'h0011, 16'd512, 16'h0011, 8, KEEP_ALL, 0);

    // Metadata session mismatch sets a sticky error; beats keep session 5.
    tx_mode = 2;
    do_packet(16'h0005, 16'd200, 16'h0009, 3, KEEP_ALL, 1);
    do_packet(16'h0006, 16'd100, 16'h0006, 2, KEEP_ALL, 1);

    // Partial last beat: 64 + 32 bytes.
    tx_mode = 0;
    do_packet(16'h0022, 16'd96, 16'h0022, 2, {32'h0, 32'hFFFF_FFFF}, 1);

    // Reset in the middle of a 4-beat packet, with one beat held in the output register.
    tx_mode = 3;
    send_notif(16'h0033, 16'd256, 1'b0);
    serve_req();
    send_meta(16'h0033);
    send_beat(rand_data(), KEEP_ALL, 1'b0, 0);
    data_tvalid = 1'b0;
    clk_step();
    check("held_pkt_valid", pkt_tvalid, 1'b1);
    rst = 1'b1;
    clk_step();
    model_reset();
    check("midrst_pkt_valid", pkt_tvalid, 1'b0);
    check("midrst_notif_ready", notif_tready, 1'b0);
    check("midrst_meta_ready", meta_tready, 1'b0);
    check("midrst_data_ready", data_tready, 1'b0);
    check("midrst_req_valid", req_tvalid, 1'b0);
    check_stats();
    rst = 1'b0;
    tx_mode = 0;
    clk_step();
    check("post_rst_idle", notif_tready, 1'b1);
    check("post_rst_pkt_valid", pkt_tvalid, 1'b0);
    do_packet(16'h0044, 16'd128, 16'h0044, 2, KEEP_ALL, 0);

    // Randomized traffic.
    tx_mode = 2;
    for (int n = 0; n < 12; n++) begin
      logic [15:0] sid;
      logic [15:0] len;
      logic        closed;
      sid    = 16'($urandom);
      len    = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      closed = ($urandom_range(0, 4) == 0);
      if (closed || len == 16'd0) begin
        send_notif(sid, len, closed);
        clk_step();
        check_stats();
      end else begin
        do_packet(sid, len, ($urandom_range(0, 3) == 0) ? sid ^ 16'h0100 : sid,
                  int'($urandom_range(1, 5)), rand_keep(), 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_receiver.md
Name: pkt_receiver

Overview:
- RX-side counterpart of the TCP TX packet sender.
- Consumes TCP/IP stack RX notifications, issues read requests, accepts RX metadata and payload beats.
- Emits a packet stream into the top-k kernel in the same packed format the sender consumes: {metadata, tlast, tdata}.
- Handles one read transaction at a time; closed/zero-length notifications are dropped and counted.

Parameters:
- NOTIF_W, 88, notification width: [15:0] sessionID, [31:16] length in bytes, [63:32] IP, [79:64] dstPort, [80] closed
- DATA_W, 512, payload width (bits)
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_notifications_TDATA  in  NOTIF_W  RX notification
- s_axis_notifications_TVALID  in  1  notification valid
- s_axis_notifications_TREADY  out  1  notification ready
- m_axis_read_package_TDATA  out  32  read request {length[31:16], sessionID[15:0]}
- m_axis_read_package_TVALID  out  1  request valid
- m_axis_read_package_TREADY  in  1  request ready
- s_axis_rx_metadata_TDATA  in  16  sessionID of returned data
- s_axis_rx_metadata_TVALID  in  1  metadata valid
- s_axis_rx_metadata_TREADY  out  1  metadata ready
- s_axis_rx_data_TDATA  in  DATA_W  payload beat
- s_axis_rx_data_TKEEP  in  DATA_W/8  byte enables (ignored for forwarding; used for byte count)
- s_axis_rx_data_TLAST  in  1  last beat
- s_axis_rx_data_TVALID  in  1  payload valid
- s_axis_rx_data_TREADY  out  1  payload ready
- pkt_tx_TDATA  out  DATA_W+33  [511:0] data, [512] tlast, [528:513] sessionID, [544:529] length
- pkt_tx_TVALID  out  1  packet beat valid
- pkt_tx_TREADY  in  1  downstream ready
- stat_pkts  out  CNT_W  packets (TLAST beats) forwarded
- stat_bytes  out  CNT_W  sum of popcount(TKEEP) over forwarded beats
- stat_dropped  out  CNT_W  notifications dropped
- err_session_mismatch  out  1  sticky: rx metadata sessionID differed from requested

Behaviour:
- Reset: FSM to IDLE; all TVALID/TREADY outputs 0; counters 0; err flag 0; output register empty.
- FSM states: IDLE, REQ, META, DATA.
- IDLE: notifications TREADY=1. On handshake:
  - If closed=1 or length=0: increment stat_dropped, stay IDLE.
  - Otherwise latch session and length, go REQ.
- REQ: read_package TVALID=1 with latched {length, session}. On handshake go META. TVALID stays high and data stays stable until accepted.
- META: rx_metadata TREADY=1. On handshake:
  - If TDATA != latched session, set err_session_mismatch (sticky until rst).
  - Go DATA. Forwarded metadata field always carries the latched session/length.
- DATA: rx_data TREADY = output register empty OR pkt_tx_TREADY.
  - Each accepted beat is loaded into the output register the same cycle: {length, session, TLAST, TDATA}.
  - Beat with TLAST accepted: stat_pkts++, go IDLE.
- Output register: one entry.
  - pkt_tx_TVALID is set on load and cleared on downstream handshake with no simultaneous load.
  - Simultaneous unload and load replaces the contents, so full throughput (1 beat/clk) holds while pkt_tx_TREADY=1.
  - Latency from rx_data handshake to pkt_tx_TVALID: 1 cycle.
- stat_bytes adds popcount(TKEEP) for each accepted beat. Counters wrap modulo 2^CNT_W.
- Notifications are not accepted outside IDLE (backpressure via TREADY=0). No notification buffering.
- Data arriving in IDLE/REQ/META is not accepted (TREADY=0).
- Simultaneous events:
  - In DATA: a last-beat accept and a pkt_tx unload in the same cycle are both honoured.
  - In IDLE: the next notification may be accepted in the cycle after TLAST accept.
- rst mid-transaction aborts immediately: the output register beat is discarded, nothing is reissued.

Test Plan:
- Notification session=0x0005, length=128 → read_package TDATA=0x00800005. rx_metadata=0x0005 plus 2 beats (last on 2nd) → 2 pkt_tx beats, [528:513]=0x0005, [544:529]=0x0080, [512]=0,1. stat_pkts=1, stat_bytes=128.
- Notification with closed=1, then one with length=0 → no read request issued, stat_dropped=2, FSM stays IDLE.
- pkt_tx_TREADY toggling 1/0 every cycle during an 8-beat packet → all 8 beats delivered in order, none duplicated or lost. rx_data_TREADY is never high while the register is full and unloading is blocked.
- rx_metadata=0x0009 after request for session 0x0005 → err_session_mismatch=1 and stays 1. Forwarded beats still carry session 0x0005.
- Last beat TKEEP=0x0000_0000_FFFF_FFFF in a 2-beat packet → stat_bytes increases by 96.
- rst asserted in DATA after 1 of 4 beats → all outputs and counters 0 next cycle. A new notification is then served normally.
